btn_debounce: RTL and testbench

- Input-side companion to the LED output path: conditions the on-board pushbuttons BTN[1:0] into clean, registered events for downstream counters and FSMs.
- Per button: 2-FF synchronizer, tick-based debounce FSM, debounced level, and one-cycle press/release/long-hold pulses.
- Sits directly behind the top-level BTN pins and runs on the 8 MHz PCLK.
- Sized for xc2c256 macrocell budget.

---
 rtl/btn_debounce_pkg.sv | 22 ++
 rtl/btn_debounce_if.sv | 30 +++
 rtl/btn_debounce_ch.sv | 121 ++++++++++++
 rtl/btn_debounce.sv | 53 +++++
 tb/tb_btn_debounce.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the pushbutton conditioner: debounce FSM state
// encodings and a width helper for counter sizing.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        S_RELEASED  = 2'd0,
        S_PRESS_CHK = 2'd1,
        S_PRESSED   = 2'd2,
        S_REL_CHK   = 2'd3
    } btn_state_t;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Pin-side bundle of the pushbutton conditioner: raw buttons in, debounced
// level, event pulses and the shared prescaler tick out.
interface btn_debounce_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] BTN;
    logic [N_BTN-1:0] LEVEL;
    logic [N_BTN-1:0] PRESS;
    logic [N_BTN-1:0] RELEASE;
    logic [N_BTN-1:0] HOLD;
    logic             TICK;

    modport master (
        output BTN,
        input  LEVEL,
        input  PRESS,
        input  RELEASE,
        input  HOLD,
        input  TICK
    );

    modport slave (
        input  BTN,
        output LEVEL,
        output PRESS,
        output RELEASE,
        output HOLD,
        output TICK
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, tick-qualified debounce FSM and
// registered level / press / release / hold outputs.
//
// state       | meaning
// S_RELEASED  | idle, button not pressed
// S_PRESS_CHK | s high, counting stable ticks before accepting a press
// S_PRESSED   | press accepted, counting ticks toward HOLD
// S_REL_CHK   | s low while pressed, counting stable ticks before release
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int DEB_TICKS  = 10,
    parameter int HOLD_TICKS = 500,
    parameter int ACTIVE_LOW = 0
) (
    input  logic PCLK,
    input  logic RST_N,
    input  logic tick,
    input  logic btn,
    output logic level,
    output logic press,
    output logic rel,
    output logic hold
);
    localparam int DW = clog2(HOLD_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [DW-1:0] HOLD_LAST = DW'(HOLD_TICKS - 1);
    localparam logic [DW-1:0] HOLD_MAX  = DW'(HOLD_TICKS);
    localparam logic          PIN_IDLE  = (ACTIVE_LOW != 0);

    logic          sync_q1;
    logic          sync_q2;
    logic          s;
    btn_state_t    state;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] hcnt;

    // Flops reset to the pin's idle level so s starts out as "not pressed".
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q1 <= PIN_IDLE;
            sync_q2 <= PIN_IDLE;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2 ^ PIN_IDLE;

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_RELEASED;
            dcnt  <= '0;
            hcnt  <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            hold  <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            hold  <= 1'b0;
            case (state)
                S_RELEASED: begin
                    if (s) begin
                        state <= S_PRESS_CHK;
                        dcnt  <= '0;
                    end
                end
                S_PRESS_CHK: begin
                    if (!s) begin
                        state <= S_RELEASED;
                    end else if (tick) begin
                        if (dcnt == DEB_LAST) begin
                            state <= S_PRESSED;
                            dcnt  <= '0;
                            press <= 1'b1;
                            level <= 1'b1;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                end
                S_PRESSED: begin
                    // dcnt is borrowed for release debounce; park the hold count.
                    if (!s) begin
                        state <= S_REL_CHK;
                        hcnt  <= dcnt;
                        dcnt  <= '0;
                    end else if (tick && (dcnt != HOLD_MAX)) begin
                        dcnt <= dcnt + DW'(1);
                        if (dcnt == HOLD_LAST) begin
                            hold <= 1'b1;
                        end
                    end
                end
                S_REL_CHK: begin
                    if (s) begin
                        state <= S_PRESSED;
                        dcnt  <= hcnt;
                    end else if (tick) begin
                        if (dcnt == DEB_LAST) begin
                            state <= S_RELEASED;
                            dcnt  <= '0;
                            hcnt  <= '0;
                            rel   <= 1'b1;
                            level <= 1'b0;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                end
                default: begin
                    state <= S_RELEASED;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton conditioner top: free-running debounce prescaler shared by
// N_BTN independent debounce channels.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int N_BTN      = 2,
    parameter int TICK_DIV   = 8000,
    parameter int DEB_TICKS  = 10,
    parameter int HOLD_TICKS = 500,
    parameter int ACTIVE_LOW = 0
) (
    input logic           PCLK,
    input logic           RST_N,
    btn_debounce_if.slave bus
);
    localparam int            PW      = clog2(TICK_DIV);
    localparam logic [PW-1:0] TD_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick;

    // Never re-phased by button activity, so every channel sees the same ticks.
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            pre_cnt <= '0;
        end else if (pre_cnt == TD_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    assign tick     = (pre_cnt == TD_LAST);
    assign bus.TICK = tick;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEB_TICKS  (DEB_TICKS),
            .HOLD_TICKS (HOLD_TICKS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .PCLK  (PCLK),
            .RST_N (RST_N),
            .tick  (tick),
            .btn   (bus.BTN[g]),
            .level (bus.LEVEL[g]),
            .press (bus.PRESS[g]),
            .rel   (bus.RELEASE[g]),
            .hold  (bus.HOLD[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a short prescaler and debounce window.
module tb_btn_debounce;
    logic PCLK  = 1'b0;
    logic RST_N = 1'b0;
    int   checks = 0;
    int   errors = 0;

    btn_debounce_if #(.N_BTN(2)) bus ();

    btn_debounce #(
        .N_BTN      (2),
        .TICK_DIV   (4),
        .DEB_TICKS  (3),
        .HOLD_TICKS (5),
        .ACTIVE_LOW (0)
    ) dut (
        .PCLK  (PCLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    function automatic logic [1:0] pick(input int kind);
        case (kind)
            0:       return bus.PRESS;
            1:       return bus.RELEASE;
            default: return bus.HOLD;
        endcase
    endfunction

    // Steps until a pulse of the given kind shows on a masked channel; n=0 if none.
    task automatic wait_pulse(input int kind, input logic [1:0] mask, input int limit,
                              output int n, output logic [1:0] seen);
        n    = 0;
        seen = 2'b00;
        for (int i = 1; i <= limit; i++) begin
            step();
            if ((pick(kind) & mask) != 2'b00) begin
                n    = i;
                seen = pick(kind);
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] acc;
        logic [1:0] seen;
        logic       lvl;
        int         n;
        int         ticks;

        // Reset held with both buttons pressed
        bus.BTN = 2'b11;
        RST_N   = 1'b0;
        acc     = 2'b00;
        ticks   = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            acc |= bus.LEVEL | bus.PRESS | bus.RELEASE | bus.HOLD;
            ticks += int'(bus.TICK);
        end
        check("rst_outputs", 32'(acc), 32'd0);
        check("rst_tick", 32'(ticks), 32'd0);

        // Buttons must re-qualify after reset; ticks land on cycles 3, 7, 11
        RST_N = 1'b1;
        acc   = 2'b00;
        ticks = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            acc |= bus.LEVEL | bus.PRESS | bus.RELEASE | bus.HOLD;
            ticks += int'(bus.TICK);
        end
        check("post_rst_quiet", 32'(acc), 32'd0);
        check("post_rst_ticks", 32'(ticks), 32'd3);
        wait_pulse(0, 2'b11, 10, n, seen);
        check_range("post_rst_press_lat", (n == 0) ? 0 : 11 + n, 12, 15);
        check("simul_press", 32'(seen), 32'h3);
        check("simul_level", 32'(bus.LEVEL), 32'h3);
        step();
        check("simul_press_width", 32'(bus.PRESS), 32'd0);

        bus.BTN = 2'b00;
        wait_pulse(1, 2'b11, 20, n, seen);
        check_range("simul_release_lat", n, 12, 15);
        check("simul_release", 32'(seen), 32'h3);
        check("simul_release_level", 32'(bus.LEVEL), 32'd0);
        step();

        // Clean press on channel 0
        bus.BTN = 2'b01;
        wait_pulse(0, 2'b01, 20, n, seen);
        check_range("clean_press_lat", n, 12, 15);
        check("clean_press_ch1_silent", 32'(seen), 32'h1);
        check("clean_press_level", 32'(bus.LEVEL), 32'h1);
        step();
        check("clean_press_width", 32'(bus.PRESS), 32'd0);

        // Release glitch is rejected, then a real release
        bus.BTN = 2'b00;
        acc     = 2'b00;
        lvl     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            acc |= bus.RELEASE;
            lvl &= bus.LEVEL[0];
        end
        bus.BTN = 2'b01;
        for (int i = 0; i < 20; i++) begin
            step();
            acc |= bus.RELEASE;
            lvl &= bus.LEVEL[0];
        end
        check("glitch_no_release", 32'(acc), 32'd0);
        check("glitch_level_held", 32'(lvl), 32'd1);
        bus.BTN = 2'b00;
        wait_pulse(1, 2'b01, 20, n, seen);
        check_range("release_lat", n, 12, 15);
        check("release_ch", 32'(seen), 32'h1);
        check("release_level", 32'(bus.LEVEL), 32'd0);
        step();
        check("release_width", 32'(bus.RELEASE), 32'd0);

        // Bouncing input never qualifies
        acc = 2'b00;
        for (int r = 0; r < 5; r++) begin
            bus.BTN = 2'b01;
            for (int i = 0; i < 3; i++) begin
                step();
                acc |= bus.PRESS | bus.LEVEL;
            end
            bus.BTN = 2'b00;
            for (int i = 0; i < 2; i++) begin
                step();
                acc |= bus.PRESS | bus.LEVEL;
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            acc |= bus.PRESS | bus.LEVEL;
        end
        check("bounce_rejected", 32'(acc), 32'd0);

        // Long hold on channel 1: one PRESS, one HOLD 20 cycles later, no repeat
        bus.BTN = 2'b10;
        wait_pulse(0, 2'b10, 20, n, seen);
        check_range("hold_press_lat", n, 12, 15);
        check("hold_press_ch", 32'(seen), 32'h2);
        wait_pulse(2, 2'b10, 25, n, seen);
        check_range("hold_lat", n, 17, 20);
        check("hold_ch", 32'(seen), 32'h2);
        acc = 2'b00;
        for (int i = 0; i < 40; i++) begin
            step();
            acc |= bus.HOLD | bus.PRESS;
        end
        check("no_second_hold", 32'(acc), 32'd0);
        check("hold_level", 32'(bus.LEVEL), 32'h2);
        bus.BTN = 2'b00;
        wait_pulse(1, 2'b10, 20, n, seen);
        check_range("hold_release_lat", n, 12, 15);
        check("hold_release_level", 32'(bus.LEVEL), 32'd0);

        // Reset in the middle of a press debounce
        bus.BTN = 2'b01;
        acc     = 2'b00;
        for (int i = 0; i < 8; i++) begin
            step();
            acc |= bus.PRESS;
        end
        RST_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            acc |= bus.PRESS | bus.LEVEL;
        end
        check("midrst_no_press", 32'(acc), 32'd0);
        RST_N = 1'b1;
        wait_pulse(0, 2'b01, 20, n, seen);
        check_range("midrst_press_lat", n, 12, 15);
        check("midrst_level", 32'(bus.LEVEL), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
